dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port: it accepts one load or store request at a time through a valid/ready handshake and returns the result after a fixed, parameterised latency. The block owns the word-addressed storage array. It drives a `stall` indication that the core's hazard logic uses to freeze its pipeline while a request cannot be accepted. It sits between the EX/MEM stage of the core and the data storage, and replaces the zero-latency data memory when multi-cycle memory timing is modelled.

---
 rtl/dmem_responder.sv | 73 +++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with valid/ready request port and owned storage
module dmem_responder #(
  parameter int DWIDTH = 32,
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [DWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic we, err, accept, addr_err;
  logic [AW-1:0] idx;
  logic [DWIDTH-1:0] wdata;
  logic [CW-1:0] cnt;
  assign accept = req_valid && req_ready;
  assign stall = req_valid && !req_ready;
  assign addr_err = (req_addr[1:0] != 2'b0) || ((req_addr >> (AW + 2)) != '0);
  // The access happens on the last WAIT edge, so a reset on that same edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            if (we && !err) mem[idx] <= wdata;
            resp_rdata <= (we || err) ? '0 : mem[idx];
            resp_err <= err;
            resp_valid <= 1'b1;
            req_ready <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          if (accept) begin
            we <= req_we;
            wdata <= req_wdata;
            idx <= req_addr[AW+1:2];
            err <= addr_err;
            cnt <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks two responder instances (LATENCY 2 and 1) against a word-array reference model
module tb_dmem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst [2];
  logic v [2];
  logic we [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic rdy [2];
  logic rv [2];
  logic re [2];
  logic st [2];
  int checks = 0;
  int fails = 0;
  logic [31:0] ref_mem [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DWIDTH(32), .DEPTH(DEPTH), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(v[0]), .req_we(we[0]), .req_addr(addr[0]),
    .req_wdata(wd[0]), .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
    .resp_err(re[0]), .stall(st[0]));

  dmem_responder #(.DWIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(v[1]), .req_we(we[1]), .req_addr(addr[1]),
    .req_wdata(wd[1]), .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
    .resp_err(re[1]), .stall(st[1]));

  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_r;
    logic exp_e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic clear_model(input int i);
    for (int k = 0; k < DEPTH; k++) ref_mem[i][k] = '0;
  endtask

  task automatic run_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r, output logic e, output int lat);
    int n;
    @(negedge clk);
    v[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
    n = 0;
    while (rdy[i] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    lat = -1; r = '0; e = 1'b0;
    if (n >= 20) begin v[i] = 1'b0; return; end
    @(negedge clk);
    v[i] = 1'b0;
    n = 0;
    while (rv[i] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rv[i] === 1'b1) begin
      lat = n; r = rd[i]; e = re[i];
      @(negedge clk);
      chk("resp_pulse_drop", {31'b0, rv[i]}, 32'd0);
    end
  endtask

  task automatic model_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r, output logic e);
    int lat;
    logic er;
    logic [31:0] exp_r;
    run_req(i, w, a, d, r, e, lat);
    er = (a % 4 != 0) || (a >= DEPTH * 4);
    exp_r = (!w && !er) ? ref_mem[i][(a / 4) % DEPTH] : 32'd0;
    if (w && !er) ref_mem[i][a / 4] = d;
    chk($sformatf("latency[%0d] a=%h", i, a), lat, lat_of(i));
    chk($sformatf("rdata[%0d] a=%h", i, a), r, exp_r);
    chk($sformatf("err[%0d] a=%h", i, a), {31'b0, e}, {31'b0, er});
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [10];
    logic [31:0] r;
    logic e;
    int k, pulses, rq, j;
    logic prev_rdy, acc_now, cw;
    logic [31:0] ca, exp_r;
    tbl[0] = '{1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 32'h12, 32'h55, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 32'h400, 32'h66, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 32'h12, 32'h0, 32'h0, 1'b1};
    tbl[8] = '{1'b1, 32'h3FC, 32'hAAAA5555, 32'h0, 1'b0};
    tbl[9] = '{1'b0, 32'h3FC, 32'h0, 32'hAAAA5555, 1'b0};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; v[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
      clear_model(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {31'b0, rdy[i]}, 32'd1);
      chk("rst_rv", {31'b0, rv[i]}, 32'd0);
      chk("rst_err", {31'b0, re[i]}, 32'd0);
      chk("rst_rdata", rd[i], 32'd0);
      chk("rst_stall", {31'b0, st[i]}, 32'd0);
    end
    for (int t = 0; t < 10; t++) begin
      model_req(0, tbl[t].w, tbl[t].a, tbl[t].d, r, e);
      chk($sformatf("tbl%0d_rdata", t), r, tbl[t].exp_r);
      chk($sformatf("tbl%0d_err", t), {31'b0, e}, {31'b0, tbl[t].exp_e});
    end
    // continuous valid: four alternating store/load requests, accepts expected at edges 1,4,7,10
    @(negedge clk);
    k = 0; pulses = 0; rq = 0;
    v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wd[0] = 32'hC0DE0000;
    prev_rdy = rdy[0];
    for (j = 1; j <= 14; j++) begin
      @(negedge clk);
      acc_now = v[0] && prev_rdy;
      chk($sformatf("cont_accept_c%0d", j), {31'b0, acc_now}, {31'b0, (j == 1 || j == 4 || j == 7 || j == 10)});
      chk($sformatf("cont_stall_c%0d", j), {31'b0, st[0]}, {31'b0, (j % 3 != 0 && j <= 10)});
      chk($sformatf("cont_rv_c%0d", j), {31'b0, rv[0]}, {31'b0, (j % 3 == 0 && j <= 12)});
      if (rv[0] === 1'b1) begin
        pulses++;
        cw = (rq % 2 == 0);
        ca = 32'h80 + 32'(rq / 2) * 4;
        exp_r = cw ? 32'd0 : ref_mem[0][ca / 4];
        if (cw) ref_mem[0][ca / 4] = 32'hC0DE0000 + 32'(rq);
        chk($sformatf("cont_rdata%0d", rq), rd[0], exp_r);
        rq++;
      end
      if (acc_now) begin
        k++;
        if (k < 4) begin
          we[0] = (k % 2 == 0); addr[0] = 32'h80 + 32'(k / 2) * 4; wd[0] = 32'hC0DE0000 + 32'(k);
        end else begin
          v[0] = 1'b0;
        end
      end
      prev_rdy = rdy[0];
    end
    chk("cont_pulses", pulses, 32'd4);
    // reset one edge into WAIT aborts a store
    @(negedge clk);
    v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h1234;
    @(negedge clk);
    v[0] = 1'b0; rst[0] = 1'b1;
    chk("abort1_rv_wait", {31'b0, rv[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort1_ready", {31'b0, rdy[0]}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      chk("abort1_no_rv", {31'b0, rv[0]}, 32'd0);
      @(negedge clk);
    end
    // reset coinciding with the access edge
    v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h24; wd[0] = 32'h5678;
    @(negedge clk);
    v[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort2_ready", {31'b0, rdy[0]}, 32'd1);
    chk("abort2_no_rv", {31'b0, rv[0]}, 32'd0);
    @(negedge clk);
    chk("abort2_no_rv_late", {31'b0, rv[0]}, 32'd0);
    clear_model(0);
    model_req(0, 1'b0, 32'h20, 32'h0, r, e);
    chk("abort1_load", r, 32'd0);
    model_req(0, 1'b0, 32'h24, 32'h0, r, e);
    chk("abort2_load", r, 32'd0);
    model_req(0, 1'b0, 32'h10, 32'h0, r, e);
    chk("reset_cleared_word", r, 32'd0);
    // LATENCY = 1 instance
    model_req(1, 1'b1, 32'h4, 32'hCAFEF00D, r, e);
    model_req(1, 1'b0, 32'h4, 32'h0, r, e);
    chk("lat1_load", r, 32'hCAFEF00D);
    // randomized traffic against the model on both instances
    for (int n = 0; n < 60; n++) begin
      int i, sel;
      logic [31:0] a;
      i = n % 2;
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? ($urandom_range(0, 255) * 4 + $urandom_range(1, 3)) :
          (sel == 1) ? (32'd1024 + $urandom_range(0, 1000) * 4) :
          ($urandom_range(0, 15) * 4);
      model_req(i, 1'($urandom_range(0, 1)), a, $urandom, r, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
